cla_sub16_pipe: RTL and testbench

Pipelined 16-bit subtractor computing D = ADD_1 − ADD_2 − BIN in four 4-bit lookahead slices, one slice per pipeline stage, with the borrow registered between stages. It is the inverse-direction companion to the 16-bit carry-lookahead adder and serves the autoencoder datapath for error and gradient terms (target − output, weight − update). It uses a valid/ready handshake on both sides, sustains one subtraction per cycle, and stalls cleanly under backpressure.

---
 rtl/cla_sub16_pipe.sv | 164 ++++++++++++++++
 tb/tb_cla_sub16_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_sub16_pipe.sv
// cla_sub16_pipe: four-stage pipelined 16-bit subtractor, D = ADD_1 - ADD_2 - BIN.
// Each stage resolves one 4-bit slice with generate/propagate lookahead on
// ADD_1 and ~ADD_2; the borrow is registered between stages. Valid/ready
// handshake on both sides, one result per cycle, stalls under backpressure.
// Optional feature macro: SUB_SAT_EN (clamp D on signed overflow).
module cla_sub16_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ADD_1,
    input  logic [15:0] ADD_2,
    input  logic        BIN,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] D,
    output logic        B_OUT,
    output logic        OVF
);

    // Item state carried by stages 0..2. The borrow is kept (not the carry)
    // so a zeroed register reads as "no borrow".
    typedef struct packed {
        logic        valid;
        logic        borrow;
        logic [15:0] res;
        logic [15:0] a;
        logic [15:0] b;
        logic        sign_a;
        logic        sign_b;
    } stage_t;

    stage_t      st   [3];
    stage_t      prev [3];
    stage_t      nxt  [3];

    // Final stage holds only what the output needs.
    logic        v3;
    logic        borrow3;
    logic [15:0] res3;
    logic        ovf3;

    logic        load0;
    logic        load1;
    logic        load2;
    logic        load3;
    logic [2:0]  load_lo;

    logic [4:0]  sum3;
    logic [15:0] res3_nxt;
    logic        ovf3_nxt;

    // 4-bit carry lookahead: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Stage advance chain: a stage loads when empty or when its occupant moves on.
    always_comb begin
        load3    = !v3 || out_ready;
        load2    = !st[2].valid || load3;
        load1    = !st[1].valid || load2;
        load0    = !st[0].valid || load1;
        load_lo  = {load2, load1, load0};
        in_ready = !rst && load0;
    end

    // Slice computation for stages 0..2; stage 0 takes the operands directly.
    always_comb begin
        logic [4:0] sum;
        sum          = '0;
        prev[0]        = '0;
        prev[0].valid  = in_valid && in_ready;
        prev[0].borrow = BIN;
        prev[0].a      = ADD_1;
        prev[0].b      = ADD_2;
        prev[0].sign_a = ADD_1[15];
        prev[0].sign_b = ADD_2[15];
        prev[1]        = st[0];
        prev[2]        = st[1];
        nxt            = '{default: '0};
        for (int unsigned k = 0; k < 3; k++) begin
            sum                 = cla4(prev[k].a[4*k +: 4], ~prev[k].b[4*k +: 4],
                                       ~prev[k].borrow);
            nxt[k]              = prev[k];
            nxt[k].borrow       = ~sum[4];
            nxt[k].res[4*k +: 4] = sum[3:0];
            // Consumed operand bits are cleared; only the upper slices travel on.
            nxt[k].a[4*k +: 4]  = '0;
            nxt[k].b[4*k +: 4]  = '0;
        end
    end

    // Top slice, overflow detection and optional clamp feeding the output stage.
    always_comb begin
        sum3            = cla4(st[2].a[15:12], ~st[2].b[15:12], ~st[2].borrow);
        res3_nxt        = st[2].res;
        res3_nxt[15:12] = sum3[3:0];
        ovf3_nxt        = (st[2].sign_a != st[2].sign_b) && (res3_nxt[15] != st[2].sign_a);
`ifdef SUB_SAT_EN
        if (ovf3_nxt) begin
            res3_nxt = st[2].sign_a ? 16'h8000 : 16'h7FFF;
        end
`endif
    end

    // Pipeline registers for stages 0..2; data only moves with a valid item.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < 3; k++) begin
                st[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (load_lo[k]) begin
                    if (prev[k].valid) begin
                        st[k] <= nxt[k];
                    end else begin
                        st[k].valid <= 1'b0;
                    end
                end
            end
        end
    end

    // Output stage register; holds its contents while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3      <= 1'b0;
            borrow3 <= 1'b0;
            res3    <= '0;
            ovf3    <= 1'b0;
        end else if (load3) begin
            v3 <= st[2].valid;
            if (st[2].valid) begin
                borrow3 <= ~sum3[4];
                res3    <= res3_nxt;
                ovf3    <= ovf3_nxt;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid = v3;
        D         = res3;
        B_OUT     = borrow3;
        OVF       = ovf3;
    end

endmodule

// File: tb/tb_cla_sub16_pipe.sv
// Self-checking bench for cla_sub16_pipe: directed vector table, backpressure,
// back-to-back random stream and mid-stream reset, with a result scoreboard.
module tb_cla_sub16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ADD_1;
    logic [15:0] ADD_2;
    logic        BIN;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        B_OUT;
    logic        OVF;

    always #5 clk = ~clk;

    cla_sub16_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ADD_1     (ADD_1),
        .ADD_2     (ADD_2),
        .BIN       (BIN),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .B_OUT     (B_OUT),
        .OVF       (OVF)
    );

`ifdef SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        res_t        exp;
    } vec_t;

    res_t sb[$];
    res_t cur_exp;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic bin);
        res_t        r;
        logic [16:0] diff;
        diff  = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        r.d   = diff[15:0];
        r.bo  = diff[16];
        r.ovf = (a[15] != b[15]) && (r.d[15] != a[15]);
        if (SAT && r.ovf) r.d = a[15] ? 16'h8000 : 16'h7FFF;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [15:0] a, input logic [15:0] b, input logic bin,
                           input res_t e);
        in_valid = 1'b1;
        ADD_1    = a;
        ADD_2    = b;
        BIN      = bin;
        cur_exp  = e;
    endtask

    // Handshakes are judged at the falling edge, where both sides are stable
    // for the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) sb.push_back(cur_exp);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got D=%0h with nothing pending", D);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("D", 32'(D), 32'(e.d));
                    check("B_OUT", 32'(B_OUT), 32'(e.bo));
                    check("OVF", 32'(OVF), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        vec_t  vecs[11];
        vec_t  bp_items[6];
        int    lat;
        int    idx;
        int    n0;
        int    drops;
        int    guard;

        vecs[0]  = '{16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0}};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
        vecs[2]  = '{16'h0010, 16'h000F, 1'b1, '{16'h0000, 1'b0, 1'b0}};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, '{SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1}};
        vecs[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, '{SAT ? 16'h7FFF : 16'h8000, 1'b1, 1'b1}};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};
        vecs[7]  = '{16'hABCD, 16'h1234, 1'b0, '{16'h9999, 1'b0, 1'b0}};
        vecs[8]  = '{16'h8000, 16'h7FFF, 1'b0, '{SAT ? 16'h8000 : 16'h0001, 1'b0, 1'b1}};
        vecs[9]  = '{16'h0FF0, 16'h0F0F, 1'b1, '{16'h00E0, 1'b0, 1'b0}};
        vecs[10] = '{16'h7FFF, 16'h8000, 1'b1, '{SAT ? 16'h7FFF : 16'hFFFE, 1'b1, 1'b1}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ADD_1 = '0; ADD_2 = '0; BIN = 1'b0; cur_exp = '0;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_B_OUT", 32'(B_OUT), 32'd0);
        check("rst_OVF", 32'(OVF), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Directed vectors one at a time: result visible after the 4th rising
        // edge counting the capture edge (3 edges after capture).
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            present(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp);
            #1;
            check("vec_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            check("latency", 32'(lat), 32'd3);
            tick();
        end

        // Backpressure: 6 offered with out_ready low, 4 held, 5th refused.
        for (int i = 0; i < 6; i++) begin
            bp_items[i].a   = 16'($urandom);
            bp_items[i].b   = 16'($urandom);
            bp_items[i].bin = 1'($urandom_range(0, 1));
            bp_items[i].exp = model(bp_items[i].a, bp_items[i].b, bp_items[i].bin);
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            present(bp_items[idx].a, bp_items[idx].b, bp_items[idx].bin, bp_items[idx].exp);
            #1;
            if (in_ready) idx++;
            if (c == 9) begin
                check("bp_held_D", 32'(D), 32'(bp_items[0].exp.d));
                check("bp_held_valid", 32'(out_valid), 32'd1);
            end
            tick();
        end
        check("bp_accepted", 32'(idx), 32'd4);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_passthrough", 32'(in_ready), 32'd1);
        guard = 0;
        while (idx < 6 && guard < 20) begin
            present(bp_items[idx].a, bp_items[idx].b, bp_items[idx].bin, bp_items[idx].exp);
            #1;
            if (in_ready) idx++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd6);
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("bp_drain", 32'(sb.size()), 32'd0);
        tick();

        // Back-to-back random stream
        out_ready = 1'b1;
        n0 = n_out;
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic        bin;
            a   = (i == 0) ? 16'hFFFF : 16'($urandom);
            b   = (i == 1) ? 16'hFFFF : 16'($urandom);
            bin = 1'($urandom_range(0, 1));
            present(a, b, bin, model(a, b, bin));
            #1;
            if (!in_ready) drops++;
            tick();
        end
        in_valid = 1'b0;
        check("b2b_in_ready", 32'(drops), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        #1;
        check("b2b_throughput", 32'(n_out - n0), 32'd100);
        tick();

        // Reset mid-stream: 3 items in flight, then a one-cycle reset.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present(16'h5555 + 16'(i), 16'h1111, 1'b0, model(16'h5555 + 16'(i), 16'h1111, 1'b0));
            #1;
            check("mid_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        tick();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_D", 32'(D), 32'd0);
        check("mid_rst_B_OUT", 32'(B_OUT), 32'd0);
        check("mid_rst_OVF", 32'(OVF), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (10) tick();
        check("no_stale", 32'(n_out - n0), 32'd0);

        // Pipeline still works after the reset.
        present(16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0});
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check("post_rst_outputs", 32'(n_out - n0), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
